// File: rtl/bmat_issue_ctrl.sv
// Issue/collect controller around the free-running simplebmat pipeline: tracks real ops with a
// valid/tag shift pipe and buffers each result in an in-order FIFO, gating issue on free credits.
module bmat_issue_ctrl #(
    parameter int LATENCY = 2,
    parameter int DEPTH   = 4,
    parameter int TAGW    = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_xoren,
    input  logic [63:0]     in_rs1,
    input  logic [63:0]     in_rs2,
    input  logic [TAGW-1:0] in_tag,
    output logic            bmat_xoren,
    output logic [63:0]     bmat_rs1,
    output logic [63:0]     bmat_rs2,
    input  logic [63:0]     bmat_rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [63:0]     out_rd,
    output logic [TAGW-1:0] out_tag,
    output logic            busy
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + LATENCY + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [LATENCY-1:0] vld_reg;
    logic [TAGW-1:0]    tag_reg [LATENCY];
    logic [63:0]        rd_mem  [DEPTH];
    logic [TAGW-1:0]    tag_mem [DEPTH];
    logic [PW-1:0]      wr_ptr_reg;
    logic [PW-1:0]      rd_ptr_reg;
    logic [CW-1:0]      count_reg;
    logic [CW-1:0]      count_next;
    logic [CW-1:0]      inflight;
    logic               fire_in;
    logic               wr_en;
    logic               pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // simplebmat samples every edge; the issue pipe alone says which samples are real ops
    assign bmat_xoren = in_xoren;
    assign bmat_rs1   = in_rs1;
    assign bmat_rs2   = in_rs2;

    assign fire_in = in_valid && in_ready;
    assign wr_en   = vld_reg[LATENCY-1];
    assign pop     = out_valid && out_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld_reg[0] <= 1'b0;
            tag_reg[0] <= '0;
        end else begin
            vld_reg[0] <= fire_in;
            tag_reg[0] <= in_tag;
        end
    end

    generate
        for (genvar gi = 1; gi < LATENCY; gi++) begin : g_stage
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    vld_reg[gi] <= 1'b0;
                    tag_reg[gi] <= '0;
                end else begin
                    vld_reg[gi] <= vld_reg[gi-1];
                    tag_reg[gi] <= tag_reg[gi-1];
                end
            end
        end
    endgenerate

    // Credits count both buffered results and ops still in the datapath, so a result always has a slot
    always_comb begin
        inflight = '0;
        for (int i = 0; i < LATENCY; i++) begin
            inflight = inflight + CW'(vld_reg[i]);
        end
    end

    assign in_ready = (count_reg + inflight) < DEPTH_C;

    always_comb begin
        count_next = count_reg;
        case ({wr_en, pop})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (wr_en) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            if (pop)   rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            count_reg <= count_next;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) begin
            rd_mem[wr_ptr_reg]  <= bmat_rd;
            tag_mem[wr_ptr_reg] <= tag_reg[LATENCY-1];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            assert (!(wr_en && !pop && count_reg == DEPTH_C));
        end
    end

    // Head is masked while empty so stale storage never shows on the outputs
    assign out_valid = (count_reg != '0);
    assign out_rd    = out_valid ? rd_mem[rd_ptr_reg]  : '0;
    assign out_tag   = out_valid ? tag_mem[rd_ptr_reg] : '0;
    assign busy      = (|vld_reg) || (count_reg != '0);

endmodule

// File: tb/tb_bmat_issue_ctrl.sv
// Directed bench for bmat_issue_ctrl with a behavioural 2-stage simplebmat model and an in-order scoreboard.
module tb_bmat_issue_ctrl;

    localparam logic [63:0] ID   = 64'h8040201008040201;
    localparam logic [63:0] ONES = 64'hFFFFFFFFFFFFFFFF;
    localparam logic [63:0] LSB8 = 64'h0101010101010101;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_xoren = 1'b0;
    logic [63:0] in_rs1 = '0;
    logic [63:0] in_rs2 = '0;
    logic [3:0]  in_tag = '0;
    logic        bmat_xoren;
    logic [63:0] bmat_rs1;
    logic [63:0] bmat_rs2;
    logic [63:0] bmat_rd;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_rd;
    logic [3:0]  out_tag;
    logic        busy;

    typedef struct {
        logic [63:0] rd;
        logic [3:0]  tag;
        int          fire_edge;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   edge_cnt = 0;
    int   pops_total = 0;
    int   fires = 0;
    int   pops_before = 0;

    logic [63:0] p0, p1;

    bmat_issue_ctrl #(.LATENCY(2), .DEPTH(4), .TAGW(4)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_xoren(in_xoren),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_tag(in_tag),
        .bmat_xoren(bmat_xoren), .bmat_rs1(bmat_rs1), .bmat_rs2(bmat_rs2), .bmat_rd(bmat_rd),
        .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd), .out_tag(out_tag),
        .busy(busy)
    );

    always #5 clock = ~clock;

    // 8x8 bit-matrix multiply: byte r of rs1 is row r, rs2 is transposed so its bytes are columns
    function automatic logic [63:0] bmat_f(input logic x, input logic [63:0] a, input logic [63:0] b);
        logic [63:0] bt;
        logic [63:0] r;
        logic [7:0]  u, v;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                bt[8*i+j] = b[8*j+i];
        for (int i = 0; i < 64; i++) begin
            u = a[8*(i/8) +: 8];
            v = bt[8*(i%8) +: 8];
            r[i] = x ? ^(u & v) : |(u & v);
        end
        return r;
    endfunction

    // simplebmat stand-in: rd valid between edges k+1 and k+2 for operands sampled at edge k
    always @(posedge clock) begin
        p0 <= bmat_f(bmat_xoren, bmat_rs1, bmat_rs2);
        p1 <= p0;
    end
    assign bmat_rd = p1;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    // Called at a negedge: checks handshake outputs against the scoreboard, then advances one clock.
    task automatic tick();
        exp_t e;
        logic exp_valid;
        exp_valid = (sb.size() > 0) && (edge_cnt >= sb[0].fire_edge + 2);
        check("in_ready", 64'(in_ready), 64'(sb.size() < 4));
        check("out_valid", 64'(out_valid), 64'(exp_valid));
        check("busy", 64'(busy), 64'(sb.size() != 0));
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("pop_with_empty_scoreboard", 64'(1), 64'(0));
            end else begin
                e = sb.pop_front();
                check("out_rd", out_rd, e.rd);
                check("out_tag", 64'(out_tag), 64'(e.tag));
                $display("pop  tag=%0d rd=%016h", out_tag, out_rd);
                pops_total++;
            end
        end
        if (in_valid && in_ready) begin
            e.rd = bmat_f(in_xoren, in_rs1, in_rs2);
            e.tag = in_tag;
            e.fire_edge = edge_cnt + 1;
            sb.push_back(e);
            fires++;
        end
        @(posedge clock);
        edge_cnt++;
        @(negedge clock);
    endtask

    initial begin
        // Reset state
        @(posedge clock); @(posedge clock); @(negedge clock);
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_out_rd", out_rd, 64'h0);
        check("rst_out_tag", 64'(out_tag), 64'(0));
        reset = 1'b0;

        // Single XOR op with identity matrices
        in_valid = 1'b1; in_xoren = 1'b1; in_rs1 = ID; in_rs2 = ID; in_tag = 4'd3;
        #1;
        check("pass_xoren", 64'(bmat_xoren), 64'(1));
        check("pass_rs1", bmat_rs1, ID);
        check("pass_rs2", bmat_rs2, ID);
        tick();
        in_valid = 1'b0;
        check("single_not_yet_valid", 64'(out_valid), 64'(0));
        tick();
        check("single_not_yet_valid2", 64'(out_valid), 64'(0));
        tick();
        check("single_valid", 64'(out_valid), 64'(1));
        check("single_rd", out_rd, ID);
        check("single_tag", 64'(out_tag), 64'(3));
        out_ready = 1'b1;
        tick();
        tick();

        // OR mode
        in_valid = 1'b1; in_xoren = 1'b0; in_rs1 = ONES; in_rs2 = LSB8; in_tag = 4'd5;
        #1;
        check("or_pass_xoren", 64'(bmat_xoren), 64'(0));
        check("or_pass_rs1", bmat_rs1, ONES);
        tick();
        in_valid = 1'b0;
        tick(); tick();
        check("or_rd", out_rd, LSB8);
        check("or_tag", 64'(out_tag), 64'(5));
        tick(); tick();

        // Streaming at full rate
        pops_before = pops_total;
        for (int i = 0; i < 40; i++) begin
            in_valid = 1'b1;
            in_xoren = 1'($urandom_range(0, 1));
            in_rs1 = {$urandom, $urandom};
            in_rs2 = {$urandom, $urandom};
            in_tag = 4'(i % 16);
            check("stream_in_ready", 64'(in_ready), 64'(1));
            tick();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("stream_pops", 64'(pops_total - pops_before), 64'(40));
        check("stream_drained", 64'(sb.size()), 64'(0));

        // Backpressure: exactly four credits
        out_ready = 1'b0;
        fires = 0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_xoren = 1'b1;
            in_rs1 = {$urandom, $urandom};
            in_rs2 = ID;
            in_tag = 4'(8 + i);
            tick();
        end
        check("bp_fires", 64'(fires), 64'(4));
        check("bp_in_ready_low", 64'(in_ready), 64'(0));
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        check("bp_ready_indep_of_out_ready", 64'(in_ready), 64'(0));
        tick();
        check("bp_ready_after_first_pop", 64'(in_ready), 64'(1));
        for (int i = 0; i < 3; i++) tick();
        check("bp_drained", 64'(sb.size()), 64'(0));

        // Full with out_ready pulsed every other cycle
        out_ready = 1'b0;
        pops_before = pops_total;
        fires = 0;
        for (int i = 0; i < 24; i++) begin
            in_valid = 1'b1;
            in_xoren = 1'($urandom_range(0, 1));
            in_rs1 = {$urandom, $urandom};
            in_rs2 = {$urandom, $urandom};
            in_tag = 4'(i % 16);
            if (i >= 6) out_ready = 1'(i % 2);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        check("full_no_loss", 64'(pops_total - pops_before), 64'(fires));

        // Reset with two in flight and two buffered
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_xoren = 1'b1;
            in_rs1 = {$urandom, $urandom};
            in_rs2 = {$urandom, $urandom};
            in_tag = 4'(12 + i);
            tick();
        end
        in_valid = 1'b0;
        check("pre_rst_out_valid", 64'(out_valid), 64'(1));
        reset = 1'b1;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'(0));
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_in_ready", 64'(in_ready), 64'(1));
        sb.delete();
        tick();
        reset = 1'b0;
        pops_before = pops_total;
        in_valid = 1'b1; in_xoren = 1'b1; in_rs1 = ID; in_rs2 = LSB8; in_tag = 4'd9;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        check("post_rst_rd", out_rd, LSB8);
        check("post_rst_tag", 64'(out_tag), 64'(9));
        for (int i = 0; i < 4; i++) tick();
        check("post_rst_single_result", 64'(pops_total - pops_before), 64'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
